// File: rtl/cmd_arb_pkg.sv
// Shared types and defaults for the command arbiter: FSM state encoding,
// soft-reset trigger pattern and the strobe/reset counter width helper.
package cmd_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WRITE,
    S_SRST,
    S_INIT
  } arb_state_e;

  localparam logic [7:0]  SRST_ADDR_DEF = 8'h01;
  localparam int unsigned SRST_DATA_DEF = 2;

  // Bits needed to count down from max(strobe, srst) - 1.
  function automatic int unsigned cnt_width(input int unsigned strobe_cycles,
                                            input int unsigned srst_cycles);
    int unsigned m;
    m = (strobe_cycles > srst_cycles) ? strobe_cycles : srst_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/cmd_rr_arb.sv
// Combinational rotating-priority arbiter: search starts one past ptr_i
// (the last granted source) and returns a one-hot grant.
module cmd_rr_arb #(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_SRC-1:0] gnt_o
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    gnt_o = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      idx = PTR_W'((32'(ptr_i) + k) % N_SRC);
      if (gnt_o == '0 && req_i[idx]) gnt_o[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Multi-source command arbiter for the counter register bus.
// Define CMD_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module cmd_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 200000000,
  parameter int unsigned N_SRC         = 2,
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned STROBE_CYCLES = CLK_FREQ / 2500000,
  parameter int unsigned SRST_CYCLES   = CLK_FREQ / 1000,
  parameter logic [ADDR_W-1:0] SRST_ADDR = ADDR_W'(SRST_ADDR_DEF),
  parameter logic [DATA_W-1:0] SRST_DATA = DATA_W'(SRST_DATA_DEF)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [N_SRC-1:0]          we_addr,
  input  logic [N_SRC*ADDR_W-1:0]   addr_in,
  input  logic [N_SRC-1:0]          write,
  input  logic [N_SRC*DATA_W-1:0]   data_in,
  output logic [ADDR_W-1:0]         addr,
  output logic                      addr_we,
  output logic [DATA_W-1:0]         data_out,
  output logic                      sw_out,
  output logic                      reset_out,
  output logic [N_SRC-1:0]          ack,
  output logic [N_SRC-1:0]          overrun,
  output logic                      busy
);

  localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CNT_W = cnt_width(STROBE_CYCLES, SRST_CYCLES);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SRST_LAST   = CNT_W'(SRST_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_SRC-1:0]  ack_q, ack_d;

  logic [N_SRC-1:0]  pa_q, pw_q, ovr_q;
  logic              init_pend_q;
  logic [ADDR_W-1:0] a_pay_q [N_SRC];
  logic [DATA_W-1:0] w_pay_q [N_SRC];

  logic [N_SRC-1:0]  clr_a, clr_w, gnt;
  logic              clr_init, grant_cmd;
  logic [PTR_W-1:0]  ptr, sel_idx;

`ifdef CMD_ARB_RR_EN
  logic [PTR_W-1:0] ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ptr_q <= PTR_W'(N_SRC - 1);
    else if (grant_cmd) ptr_q <= sel_idx;
  end

  assign ptr = ptr_q;
`else
  // Pinning "last granted" to the top index makes the search start at source 0.
  assign ptr = PTR_W'(N_SRC - 1);
`endif

  cmd_rr_arb #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i (pa_q | pw_q),
    .ptr_i (ptr),
    .gnt_o (gnt)
  );

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (gnt[i]) sel_idx = PTR_W'(i);
    end
  end

  // A request coinciding with the grant of its slot re-arms it without overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pa_q        <= '0;
      pw_q        <= '0;
      ovr_q       <= '0;
      init_pend_q <= 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        a_pay_q[i] <= '0;
        w_pay_q[i] <= '0;
      end
    end else begin
      init_pend_q <= init | (init_pend_q & ~clr_init);
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (we_addr[i]) begin
          a_pay_q[i] <= addr_in[i*ADDR_W +: ADDR_W];
          pa_q[i]    <= 1'b1;
          if (pa_q[i] && !clr_a[i]) ovr_q[i] <= 1'b1;
        end else if (clr_a[i]) begin
          pa_q[i] <= 1'b0;
        end
        if (write[i]) begin
          w_pay_q[i] <= data_in[i*DATA_W +: DATA_W];
          pw_q[i]    <= 1'b1;
          if (pw_q[i] && !clr_w[i]) ovr_q[i] <= 1'b1;
        end else if (clr_w[i]) begin
          pw_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ack_d     = '0;
    clr_a     = '0;
    clr_w     = '0;
    clr_init  = 1'b0;
    grant_cmd = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (init_pend_q) begin
          state_d  = S_INIT;
          addr_d   = '0;
          clr_init = 1'b1;
        end else if (gnt != '0) begin
          grant_cmd = 1'b1;
          ack_d     = gnt;
          cnt_d     = STROBE_LAST;
          if (pa_q[sel_idx]) begin
            state_d = S_ADDR;
            addr_d  = a_pay_q[sel_idx];
            clr_a   = gnt;
          end else begin
            state_d = S_WRITE;
            data_d  = w_pay_q[sel_idx];
            clr_w   = gnt;
          end
        end
      end
      S_ADDR: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          if (addr_q == SRST_ADDR && data_q == SRST_DATA) begin
            state_d = S_SRST;
            addr_d  = '0;
            cnt_d   = SRST_LAST;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SRST: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_INIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_we   = (state_q == S_ADDR);
    sw_out    = (state_q == S_WRITE);
    reset_out = (state_q == S_SRST);
    busy      = (state_q != S_IDLE);
  end

  assign addr     = addr_q;
  assign data_out = data_q;
  assign ack      = ack_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: a transaction-level model predicts every
// grant (edge, source, kind, payload, soft reset) and a monitor checks the bus.
module tb_cmd_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int S  = 4;
  localparam int R  = 10;
  localparam logic [AW-1:0] SRST_A = 8'h01;
  localparam logic [DW-1:0] SRST_D = 32'd2;
  localparam int K_INIT = 0, K_ADDR = 1, K_WRITE = 2;

  logic            clk, reset, init;
  logic [N-1:0]    we_addr, write;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] data_in;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data_out;
  logic            addr_we, sw_out, reset_out, busy;
  logic [N-1:0]    ack, overrun;

  cmd_arbiter #(
    .N_SRC         (N),
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .STROBE_CYCLES (S),
    .SRST_CYCLES   (R),
    .SRST_ADDR     (SRST_A),
    .SRST_DATA     (SRST_D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .we_addr   (we_addr),
    .addr_in   (addr_in),
    .write     (write),
    .data_in   (data_in),
    .addr      (addr),
    .addr_we   (addr_we),
    .data_out  (data_out),
    .sw_out    (sw_out),
    .reset_out (reset_out),
    .ack       (ack),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    int unsigned t;
    int          kind;
    int          src;
    logic [63:0] pay;
    bit          srst;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: pending slots plus the edge at which the bus is next free.
  bit          m_pa [N];
  bit          m_pw [N];
  bit          m_ovr[N];
  logic [AW-1:0] m_a[N];
  logic [DW-1:0] m_w[N];
  bit          m_init;
  int unsigned idle_from;
  int          m_last;
  logic [AW-1:0] m_addr;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pa[i] = 0; m_pw[i] = 0; m_ovr[i] = 0; m_a[i] = '0; m_w[i] = '0;
    end
    m_init = 0; idle_from = 0; m_last = N - 1; m_addr = '0;
    exp_q.delete();
  endfunction

  function automatic int pick();
`ifdef CMD_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (m_pa[idx] || m_pw[idx]) return idx;
    end
`else
    for (int k = 0; k < N; k++) if (m_pa[k] || m_pw[k]) return k;
`endif
    return -1;
  endfunction

  function automatic bit model_busy_or_pending(input int unsigned next_edge);
    bit p;
    p = m_init || (next_edge < idle_from);
    for (int i = 0; i < N; i++) p = p || m_pa[i] || m_pw[i];
    return p;
  endfunction

  function automatic logic [N-1:0] m_ovr_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_ovr[i];
    return v;
  endfunction

  function automatic void model_step(input int unsigned t, input logic i_init,
                                     input logic [N-1:0] wa, input logic [N*AW-1:0] av,
                                     input logic [N-1:0] wr, input logic [N*DW-1:0] dv);
    int s;
    bit sr;
    if (t >= idle_from) begin
      if (m_init) begin
        m_init = 0;
        m_addr = '0;
        exp_q.push_back('{t, K_INIT, 0, 64'h0, 1'b0});
        idle_from = t + 2;
      end else begin
        s = pick();
        if (s >= 0) begin
          if (m_pa[s]) begin
            m_pa[s] = 0;
            m_addr  = m_a[s];
            exp_q.push_back('{t, K_ADDR, s, 64'(m_a[s]), 1'b0});
            idle_from = t + S + 1;
          end else begin
            m_pw[s] = 0;
            sr = (m_addr == SRST_A) && (m_w[s] == SRST_D);
            exp_q.push_back('{t, K_WRITE, s, 64'(m_w[s]), sr});
            idle_from = t + S + 1 + (sr ? R : 0);
            if (sr) m_addr = '0;
          end
          m_last = s;
        end
      end
    end
    if (i_init) m_init = 1;
    for (int i = 0; i < N; i++) begin
      if (wa[i]) begin
        if (m_pa[i]) m_ovr[i] = 1;
        m_pa[i] = 1;
        m_a[i]  = av[i*AW +: AW];
      end
      if (wr[i]) begin
        if (m_pw[i]) m_ovr[i] = 1;
        m_pw[i] = 1;
        m_w[i]  = dv[i*DW +: DW];
      end
    end
  endfunction

  // One clock of stimulus: inputs are sampled at the next rising edge.
  task automatic tick(input logic i_init, input logic [N-1:0] wa, input logic [N*AW-1:0] av,
                      input logic [N-1:0] wr, input logic [N*DW-1:0] dv);
    init = i_init; we_addr = wa; addr_in = av; write = wr; data_in = dv;
    model_step(cyc + 1, i_init, wa, av, wr, dv);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, '0, '0, '0);
  endtask

  task automatic wr1(input int s, input logic [DW-1:0] d);
    logic [N-1:0]    w;
    logic [N*DW-1:0] dv;
    w = '0; dv = '0;
    w[s] = 1'b1;
    dv[s*DW +: DW] = d;
    tick(1'b0, '0, '0, w, dv);
  endtask

  task automatic aw1(input int s, input logic [AW-1:0] a, input bit also_w, input logic [DW-1:0] d);
    logic [N-1:0]    wa, w;
    logic [N*AW-1:0] av;
    logic [N*DW-1:0] dv;
    wa = '0; w = '0; av = '0; dv = '0;
    wa[s] = 1'b1;
    av[s*AW +: AW] = a;
    if (also_w) begin
      w[s] = 1'b1;
      dv[s*DW +: DW] = d;
    end
    tick(1'b0, wa, av, w, dv);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (g < 500 && model_busy_or_pending(cyc + 1)) begin
      idle(1);
      g++;
    end
    idle(4);
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_addr"},      64'(addr),      64'd0);
    chk({tag, "_addr_we"},   64'(addr_we),   64'd0);
    chk({tag, "_data_out"},  64'(data_out),  64'd0);
    chk({tag, "_sw_out"},    64'(sw_out),    64'd0);
    chk({tag, "_reset_out"}, 64'(reset_out), 64'd0);
    chk({tag, "_ack"},       64'(ack),       64'd0);
    chk({tag, "_overrun"},   64'(overrun),   64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  // Monitor: every ack (or a busy cycle with no ack, i.e. init) consumes one expectation.
  initial begin : monitor
    exp_t e;
    int   len;
    bit   bad, aborted, strb;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (ack !== '0 || busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", {ack, busy}, 64'd0);
          continue;
        end
        e = exp_q.pop_front();
        chk("grant_cycle", 64'(cyc), 64'(e.t));
        if (e.kind == K_INIT) begin
          chk("init_ack",     64'(ack), 64'd0);
          chk("init_addr",    64'(addr), 64'd0);
          chk("init_strobes", 64'({addr_we, sw_out, reset_out}), 64'd0);
        end else begin
          chk("ack_src", 64'(ack), 64'd1 << e.src);
          len = 0; bad = 0; aborted = 0;
          strb = (e.kind == K_ADDR) ? addr_we : sw_out;
          while (strb && len < 64) begin
            len++;
            if (((e.kind == K_ADDR) ? 64'(addr) : 64'(data_out)) !== e.pay) bad = 1;
            if ({addr_we, sw_out} !== ((e.kind == K_ADDR) ? 2'b10 : 2'b01)) bad = 1;
            @(negedge clk);
            if (reset) begin aborted = 1; break; end
            strb = (e.kind == K_ADDR) ? addr_we : sw_out;
          end
          if (!aborted) begin
            chk("strobe_len", 64'(len), 64'(S));
            chk("payload_held", 64'(bad), 64'd0);
            if (e.kind == K_WRITE) begin
              if (e.srst) begin
                chk("srst_addr", 64'(addr), 64'd0);
                len = 0;
                while (reset_out && len < R + 8) begin
                  len++;
                  @(negedge clk);
                  if (reset) begin aborted = 1; break; end
                end
                if (!aborted) chk("srst_len", 64'(len), 64'(R));
              end else begin
                chk("no_srst", 64'(reset_out), 64'd0);
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic            iv;
    logic [N-1:0]    wa, wr;
    logic [N*AW-1:0] av;
    logic [N*DW-1:0] dv;
    int              rem0, rem1, guard;

    reset = 1'b1; init = 1'b0; we_addr = '0; write = '0; addr_in = '0; data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single write: ack one edge after sampling, 4-cycle strobe.
    wr1(0, 32'hA5);
    drain("w0");

    // Address and write together on source 1: ADDR, idle, WRITE.
    aw1(1, 8'h10, 1'b1, 32'h33);
    drain("aw1");

    // Continuous writes from sources 0 and 1.
    rem0 = 3; rem1 = 3; guard = 0;
    while ((rem0 > 0 || rem1 > 0) && guard < 300) begin
      wr = '0; dv = '0;
      if (rem0 > 0 && !m_pw[0]) begin wr[0] = 1'b1; dv[0*DW +: DW] = 32'h100 + rem0; rem0--; end
      if (rem1 > 0 && !m_pw[1]) begin wr[1] = 1'b1; dv[1*DW +: DW] = 32'h200 + rem1; rem1--; end
      tick(1'b0, '0, '0, wr, dv);
      guard++;
    end
    drain("cont");

    // Soft reset pattern, with a write from source 1 arriving mid-pulse.
    aw1(0, SRST_A, 1'b1, SRST_D);
    idle(12);
    wr1(1, 32'h77);
    drain("srst");
    chk("ovr_clean", 64'(overrun), 64'(m_ovr_vec()));

    // Init wins over a simultaneous write; clears a loaded address.
    aw1(2, 8'hC3, 1'b0, '0);
    drain("ld");
    tick(1'b1, '0, '0, 3'b100, {32'h55, 64'h0});
    drain("init");

    // Overrun: source 0 writes twice while source 1 holds the bus.
    wr1(1, 32'h11);
    wr1(0, 32'h22);
    wr1(0, 32'h33);
    drain("ovr");
    chk("ovr_set", 64'(overrun), 64'(m_ovr_vec()));

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      iv = ($urandom_range(0, 40) == 0);
      wa = '0; wr = '0; av = '0; dv = '0;
      for (int s = 0; s < N; s++) begin
        wa[s] = ($urandom_range(0, 9) == 0);
        wr[s] = ($urandom_range(0, 7) == 0);
        av[s*AW +: AW] = ($urandom_range(0, 3) == 0) ? SRST_A : AW'($urandom);
        dv[s*DW +: DW] = ($urandom_range(0, 2) == 0) ? SRST_D : DW'($urandom);
      end
      tick(iv, wa, av, wr, dv);
    end
    drain("rand");
    chk("ovr_rand", 64'(overrun), 64'(m_ovr_vec()));

    // Reset asserted while sw_out is high.
    wr1(0, 32'hDEAD);
    idle(2);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_quiet("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    wr1(2, 32'hBEEF);
    drain("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
